// File: rtl/timer_countdown_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_countdown_pkg
//  Description : Shared constants and digit type for the BCD countdown timer.
//  Revision    : 1.0  initial release
// ============================================================================
package timer_countdown_pkg;

    // Largest value a single BCD digit may hold.
    localparam int BCD_MAX = 9;

    // Default largest tens-of-seconds digit (seconds run 00..59).
    localparam int SEC_TENS_MAX_DEF = 5;

    // Default largest minutes digit.
    localparam int MIN_MAX_DEF = 9;

    // One BCD digit.
    typedef logic [3:0] digit_t;

endpackage : timer_countdown_pkg
`default_nettype wire

// File: rtl/timer_countdown_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_countdown_if
//  Description : Keypad/tick inputs and display/status outputs of the
//                countdown timer. The master drives keypad and tick, the
//                slave (the timer) drives the digits and status.
//  Revision    : 1.0  initial release
// ============================================================================
interface timer_countdown_if;
    import timer_countdown_pkg::*;

    digit_t bcd;        // keypad digit, valid while loadn is low
    logic   loadn;      // active-low key-present level
    logic   pgt_1Hz;    // 1 Hz tick level
    logic   count_en;   // 1 = cooking, 0 = idle
    digit_t min_ones;
    digit_t sec_tens;
    digit_t sec_ones;
    logic   zero;
    logic   done;

    modport master (
        output bcd, loadn, pgt_1Hz, count_en,
        input  min_ones, sec_tens, sec_ones, zero, done
    );

    modport slave (
        input  bcd, loadn, pgt_1Hz, count_en,
        output min_ones, sec_tens, sec_ones, zero, done
    );

endinterface : timer_countdown_if
`default_nettype wire

// File: rtl/timer_countdown_bcd_down_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_digit
//  Description : Combinational single-digit BCD decrement with borrow out.
//                A zero digit asked to decrement reloads wrap_val and
//                requests a borrow from the next more significant digit.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_down_digit
    import timer_countdown_pkg::*;
(
    input  digit_t cur,
    input  logic   dec,
    input  digit_t wrap_val,
    output digit_t next,
    output logic   borrow
);

    // Decrement one digit, wrapping and borrowing when it is already zero
    always_comb begin
        next   = cur;
        borrow = 1'b0;
        if (dec) begin
            if (cur == 4'd0) begin
                next   = wrap_val;
                borrow = 1'b1;
            end else begin
                next   = cur - 4'd1;
            end
        end
    end

endmodule : bcd_down_digit
`default_nettype wire

// File: rtl/timer_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : timer_countdown
//  Description : BCD M:SS countdown register. Keypad digits shift in from
//                the right while idle; the count drops by one second on each
//                1 Hz tick while cooking and stops at 0:00 with a done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_countdown
    import timer_countdown_pkg::*;
#(
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
    parameter int MIN_MAX      = MIN_MAX_DEF
) (
    input  wire logic         clk_100Hz,
    input  wire logic         clear,
    timer_countdown_if.slave  bus
);

    localparam digit_t C_BCD_MAX      = digit_t'(BCD_MAX);
    localparam digit_t C_SEC_TENS_MAX = digit_t'(SEC_TENS_MAX);
    localparam digit_t C_MIN_MAX      = digit_t'(MIN_MAX);

    digit_t min_ones_q, min_ones_d;
    digit_t sec_tens_q, sec_tens_d;
    digit_t sec_ones_q, sec_ones_d;
    logic   done_q,     done_d;
    logic   loadn_q,    loadn_d;
    logic   pgt_q,      pgt_d;

    logic   w_key_event;
    logic   w_tick_event;
    logic   w_zero;
    logic   w_entry;
    logic   w_dec;
    logic   w_apply_dec;

    digit_t w_ones_next, w_tens_next, w_min_next;
    logic   w_ones_borrow, w_tens_borrow, w_min_borrow;

    assign w_key_event  = loadn_q & ~bus.loadn;
    assign w_tick_event = ~pgt_q & bus.pgt_1Hz;
    assign w_zero       = (min_ones_q == 4'd0) && (sec_tens_q == 4'd0) &&
                          (sec_ones_q == 4'd0);

    // The shift is refused if the digits moving left would become illegal
    // in their new positions.
    assign w_entry = w_key_event && !bus.count_en && (bus.bcd <= C_BCD_MAX) &&
                     (sec_ones_q <= C_SEC_TENS_MAX) && (sec_tens_q <= C_MIN_MAX);

    assign w_dec   = w_tick_event && bus.count_en && !w_zero;

    // Ripple-borrow chain: ones -> tens -> minutes
    bcd_down_digit u_sec_ones (
        .cur      (sec_ones_q),
        .dec      (w_dec),
        .wrap_val (C_BCD_MAX),
        .next     (w_ones_next),
        .borrow   (w_ones_borrow)
    );

    bcd_down_digit u_sec_tens (
        .cur      (sec_tens_q),
        .dec      (w_ones_borrow),
        .wrap_val (C_SEC_TENS_MAX),
        .next     (w_tens_next),
        .borrow   (w_tens_borrow)
    );

    bcd_down_digit u_min_ones (
        .cur      (min_ones_q),
        .dec      (w_tens_borrow),
        .wrap_val (C_BCD_MAX),
        .next     (w_min_next),
        .borrow   (w_min_borrow)
    );

    // A borrow out of the minutes digit would be an underflow past 0:00;
    // zero gating already prevents it, this keeps the count safe regardless.
    assign w_apply_dec = w_dec & ~w_min_borrow;

    // Next-state selection: entry shift, else decrement, else hold
    always_comb begin
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        done_d     = 1'b0;
        loadn_d    = bus.loadn;
        pgt_d      = bus.pgt_1Hz;
        if (w_entry) begin
            min_ones_d = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = bus.bcd;
        end else if (w_apply_dec) begin
            min_ones_d = w_min_next;
            sec_tens_d = w_tens_next;
            sec_ones_d = w_ones_next;
            done_d     = (w_min_next == 4'd0) && (w_tens_next == 4'd0) &&
                         (w_ones_next == 4'd0);
        end
    end

    // State and edge-detect registers with synchronous clear
    always_ff @(posedge clk_100Hz) begin
        if (clear) begin
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            done_q     <= 1'b0;
            loadn_q    <= 1'b1;
            pgt_q      <= 1'b0;
        end else begin
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            done_q     <= done_d;
            loadn_q    <= loadn_d;
            pgt_q      <= pgt_d;
        end
    end

    assign bus.min_ones = min_ones_q;
    assign bus.sec_tens = sec_tens_q;
    assign bus.sec_ones = sec_ones_q;
    assign bus.zero     = w_zero;
    assign bus.done     = done_q;

endmodule : timer_countdown
`default_nettype wire

// File: tb/tb_timer_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_countdown
//  Description : Scoreboard bench for timer_countdown. Stimulus updates a
//                seconds-based reference model and queues the expected
//                display for each clock; a monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_countdown;

    localparam int TENS_MAX = 5;

    typedef struct {
        int mo;
        int st;
        int so;
        int dn;
    } exp_t;

    logic clk = 1'b0;
    logic clear;
    int   total_cnt = 0;
    int   bad_cnt   = 0;
    exp_t sb[$];

    // reference model state
    int m_min, m_tens, m_ones;
    bit m_prev_ln, m_prev_pg;
    bit cur_ce;

    timer_countdown_if bus ();

    timer_countdown dut (
        .clk_100Hz (clk),
        .clear     (clear),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Monitor: one expected display per clock edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("min_ones", int'(bus.min_ones), e.mo);
            check("sec_tens", int'(bus.sec_tens), e.st);
            check("sec_ones", int'(bus.sec_ones), e.so);
            check("zero", int'(bus.zero), int'(e.mo == 0 && e.st == 0 && e.so == 0));
            check("done", int'(bus.done), e.dn);
        end
    end

    // Drive one cycle of inputs and queue the model's view after the edge
    task automatic drive(input bit clr, input int b, input bit ln, input bit pg, input bit ce);
        bit   key, tick;
        int   secs;
        exp_t e;
        @(negedge clk);
        clear        = clr;
        bus.bcd      = b[3:0];
        bus.loadn    = ln;
        bus.pgt_1Hz  = pg;
        bus.count_en = ce;
        e.dn = 0;
        if (clr) begin
            m_min = 0; m_tens = 0; m_ones = 0;
            m_prev_ln = 1'b1;
            m_prev_pg = 1'b0;
        end else begin
            key  = m_prev_ln && !ln;
            tick = !m_prev_pg && pg;
            if (key && !ce && b <= 9 && m_ones <= TENS_MAX && m_tens <= 9) begin
                m_min  = m_tens;
                m_tens = m_ones;
                m_ones = b;
            end else if (tick && ce) begin
                secs = m_min * 60 + m_tens * 10 + m_ones;
                if (secs > 0) begin
                    secs   = secs - 1;
                    m_min  = secs / 60;
                    m_tens = (secs % 60) / 10;
                    m_ones = secs % 10;
                    e.dn   = (secs == 0) ? 1 : 0;
                end
            end
            m_prev_ln = ln;
            m_prev_pg = pg;
        end
        e.mo = m_min; e.st = m_tens; e.so = m_ones;
        sb.push_back(e);
    endtask

    task automatic press(input int d, input int hold);
        for (int i = 0; i < hold; i++) drive(0, d, 0, 0, cur_ce);
        for (int i = 0; i < 3; i++)    drive(0, d, 1, 0, cur_ce);
    endtask

    task automatic tick(input int hold);
        for (int i = 0; i < hold; i++) drive(0, 0, 1, 1, cur_ce);
        for (int i = 0; i < 3; i++)    drive(0, 0, 1, 0, cur_ce);
    endtask

    task automatic do_clear(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 1, 0, cur_ce);
        drive(0, 0, 1, 0, cur_ce);
    endtask

    initial begin
        int unsigned act;
        clear = 1'b1; bus.bcd = 4'd0; bus.loadn = 1'b1;
        bus.pgt_1Hz = 1'b0; bus.count_en = 1'b0;
        cur_ce = 1'b0;
        m_min = 0; m_tens = 0; m_ones = 0;
        m_prev_ln = 1'b1; m_prev_pg = 1'b0;

        // reset
        do_clear(2);
        // entry 1:30
        press(1, 5); press(3, 5); press(0, 5);
        // rejection: 0:07 then 5 refused, then invalid digit
        do_clear(1);
        press(7, 5); press(5, 5); press(10, 5);
        // countdown from 1:00 through zero and beyond
        do_clear(1);
        press(1, 5); press(0, 5); press(0, 5);
        cur_ce = 1'b1;
        for (int i = 0; i < 63; i++) tick(2);
        // gating from 0:30
        cur_ce = 1'b0;
        do_clear(1);
        press(3, 5); press(0, 5);
        cur_ce = 1'b1;
        tick(3);
        press(4, 5);
        cur_ce = 1'b0;
        tick(3);
        // clear coincident with a tick at 0:15
        do_clear(1);
        press(1, 5); press(5, 5);
        cur_ce = 1'b1;
        drive(1, 0, 1, 1, 1);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 1);

        // randomized mix of keys, ticks, enables and clears
        for (int i = 0; i < 400; i++) begin
            act = $urandom_range(0, 9);
            if (act < 4) begin
                cur_ce = ($urandom_range(0, 4) == 0);
                press(int'($urandom_range(0, 15)), int'($urandom_range(2, 4)));
            end else if (act < 9) begin
                cur_ce = ($urandom_range(0, 4) != 0);
                tick(int'($urandom_range(2, 4)));
            end else if ($urandom_range(0, 3) == 0) begin
                do_clear(1);
            end else begin
                cur_ce = ~cur_ce;
                drive(0, 0, 1, 0, cur_ce);
            end
        end

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #2;
        total_cnt++;
        if (sb.size() != 0) begin
            bad_cnt++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_timer_countdown
`default_nettype wire
